i2c_slave_device: RTL and testbench

Responder end of the team's I2C link: a 7-bit-addressed target that oversamples `scl`/`sda` on the system clock, detects START/STOP, matches its address, ACKs, and then receives write bytes or transmits read bytes. It sits on the same open-drain bus as `master_device`. It never drives `scl` and only ever pulls `sda` low or releases it.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_slave_device_if.sv | 32 +++
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_slave_device.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_slave_device.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C responder and master blocks.
//   i2c_state_e : responder protocol states
//   I2C_BITS    : bits per byte on the bus
//   I2C_CNT_W   : width of a bit counter that spans one byte
//   I2C_ACK     : bus level that acknowledges a byte
//   I2C_NACK    : bus level that declines a byte
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam int   I2C_BITS  = 8;
  localparam int   I2C_CNT_W = $clog2(I2C_BITS);
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_slave_device_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_device_if
// Bus clock and byte-level handshake of the I2C responder.
//   scl      : bus clock seen by the responder (never driven by it)
//   tx_data  : byte to return on the next read byte
//   rx_data  : last byte received in a write
//   rx_valid : one-cycle pulse when rx_data updates
//   tx_next  : one-cycle pulse when tx_data has been taken
//   busy     : transfer with this device in progress
// The open-drain sda pin stays a plain inout port of the responder so the
// line resolution happens on a real net rather than inside the interface.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface i2c_slave_device_if;
  logic       scl;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_next;
  logic       busy;

  modport slave (
    input  scl, tx_data,
    output rx_data, rx_valid, tx_next, busy
  );

  modport master (
    output scl, tx_data,
    input  rx_data, rx_valid, tx_next, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Two-flop synchroniser plus one history flop for one bus line, with
// single-cycle edge strobes.
//   clk, rst : system clock, synchronous active-high reset
//   line_i   : asynchronous bus line
//   level    : synchronised line level
//   rise     : one-cycle strobe on a synchronised 0->1
//   fall     : one-cycle strobe on a synchronised 1->0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = line_i;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Reset to the idle-bus level so leaving reset makes no false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_slave_device.sv
// ----------------------------------------------------------------------------
// i2c_slave_device
// 7-bit addressed I2C responder. Oversamples scl/sda on clk, decodes
// START/STOP, ACKs its address, then receives write bytes or sends read bytes.
//   clk, rst : system clock, synchronous active-high reset
//   sda      : open-drain bus data, driven 0 or high-Z only
//   bus      : scl plus byte handshake (see i2c_slave_device_if)
//
// state        | meaning
// ST_IDLE      | bus free or not addressed
// ST_ADDR      | shifting in 7 address bits + R/W
// ST_ADDR_ACK  | acknowledging the address (fall to fall)
// ST_RX_BYTE   | shifting in a write data byte
// ST_RX_ACK    | acknowledging a write byte (fall to fall)
// ST_TX_BYTE   | shifting out a read data byte
// ST_TX_ACK    | waiting for the master's ACK/NACK
// ST_WAIT_STOP | not involved; only START/STOP matter
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_slave_device
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h42
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               sda,
  i2c_slave_device_if.slave bus
);

  localparam logic [I2C_CNT_W-1:0] CNT_LOAD = (I2C_CNT_W)'(I2C_BITS - 1);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync u_scl_sync (
    .clk(clk), .rst(rst), .line_i(bus.scl),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk(clk), .rst(rst), .line_i(sda),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl_level;
  assign stop  = sda_rise & scl_level;

  i2c_state_e            state_q, state_d;
  logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [I2C_BITS-1:0]   shift_q, shift_d;
  logic [I2C_BITS-1:0]   shift_in;
  logic                  rw_q, rw_d;
  logic                  mack_q, mack_d;     // master ACKed the last read byte
  logic                  sda_out_q, sda_out_d; // 1 = released, 0 = pulled low
  logic                  busy_q, busy_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_next_q, tx_next_d;

  assign shift_in = {shift_q[I2C_BITS-2:0], sda_level};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_next_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      sda_out_q  <= sda_out_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_next_q  <= tx_next_d;
    end
  end

  // sda is only ever changed on scl falls, so the block cannot fake a
  // START or STOP of its own.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    sda_out_d  = sda_out_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_next_d  = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start) begin
      state_d   = ST_ADDR;
      cnt_d     = CNT_LOAD;
      shift_d   = '0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == '0) begin
            if (shift_in[7:1] == ADDRESS) begin
              state_d = ST_ADDR_ACK;
              rw_d    = shift_in[0];
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        // First fall starts the ACK, second fall ends it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (sda_out_q != I2C_ACK) begin
            sda_out_d = I2C_ACK;
            busy_d    = 1'b1;
          end else begin
            sda_out_d = 1'b1;
            cnt_d     = CNT_LOAD;
            if (rw_q) begin
              shift_d   = bus.tx_data;
              tx_next_d = 1'b1;
              sda_out_d = bus.tx_data[7];
              state_d   = ST_TX_BYTE;
            end else begin
              state_d = ST_RX_BYTE;
            end
          end
        end
        ST_RX_BYTE: if (scl_rise) begin
          shift_d = shift_in;
          if (cnt_q == '0) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = ST_RX_ACK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          if (sda_out_q != I2C_ACK) begin
            sda_out_d = I2C_ACK;
          end else begin
            sda_out_d = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = ST_RX_BYTE;
          end
        end
        // The bit on the line is always shift_q[7]; rotating keeps it there.
        ST_TX_BYTE: if (scl_fall) begin
          if (cnt_q == '0) begin
            sda_out_d = 1'b1;
            mack_d    = 1'b0;
            state_d   = ST_TX_ACK;
          end else begin
            shift_d   = {shift_q[I2C_BITS-2:0], shift_q[I2C_BITS-1]};
            sda_out_d = shift_q[I2C_BITS-2];
            cnt_d     = cnt_q - 1'b1;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_level == I2C_NACK) begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              mack_d = 1'b1;
            end
          end else if (scl_fall && mack_q) begin
            mack_d    = 1'b0;
            shift_d   = bus.tx_data;
            tx_next_d = 1'b1;
            sda_out_d = bus.tx_data[7];
            cnt_d     = CNT_LOAD;
            state_d   = ST_TX_BYTE;
          end
        end
        default: begin
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.rx_data  = rx_data_q;
    bus.rx_valid = rx_valid_q;
    bus.tx_next  = tx_next_q;
    bus.busy     = busy_q;
  end

  assign sda = sda_out_q ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_slave_device.sv
`timescale 1ns/1ps

module tb_i2c_slave_device;
  import i2c_pkg::*;

  localparam int Q = 4;  // clk cycles per quarter scl period

  logic clk;
  logic rst;
  logic m_pull;
  wire  sda;

  i2c_slave_device_if bus ();

  pullup (sda);
  assign sda = m_pull ? 1'b0 : 1'bz;

  i2c_slave_device #(.ADDRESS(7'h42)) dut (
    .clk(clk),
    .rst(rst),
    .sda(sda),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      last_rx = bus.rx_data;
    end
    if (bus.tx_next) tx_cnt = tx_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter with scl low; leaves scl low just after the fall.
  task automatic xfer_bit(input logic b, output logic obs);
    wait_clk(Q);
    m_pull = ~b;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    obs = sda;
    wait_clk(Q);
    bus.scl = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic [7:0] obs);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], o);
      obs[i] = o;
    end
  endtask

  task automatic bus_start();
    m_pull = 1'b1;
    wait_clk(2 * Q);
    bus.scl = 1'b0;
  endtask

  task automatic bus_rep_start();
    wait_clk(Q);
    m_pull = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    m_pull = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q);
    m_pull = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    m_pull = 1'b0;
    wait_clk(2 * Q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       o;
    logic [7:0] ob;
    int         rx0, tx0;

    m_pull      = 1'b0;
    bus.scl     = 1'b1;
    bus.tx_data = 8'h3C;
    rst         = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);

    check_eq("rst_rx_data", bus.rx_data, 8'h00);
    check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
    check_eq("rst_tx_next", bus.tx_next, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_sda", sda, 1'b1);

    // Write 0x42+W, 0xA5
    rx0 = rx_cnt;
    bus_start();
    xfer_byte(8'h84, ob);
    xfer_bit(1'b1, o);
    check_eq("wr_addr_ack", o, 1'b0);
    check_eq("wr_busy", bus.busy, 1'b1);
    xfer_byte(8'hA5, ob);
    xfer_bit(1'b1, o);
    check_eq("wr_data_ack", o, 1'b0);
    check_eq("wr_rx_count", rx_cnt - rx0, 1);
    check_eq("wr_rx_data", last_rx, 8'hA5);
    bus_stop();
    check_eq("wr_busy_after_stop", bus.busy, 1'b0);

    // Read 0x42+R: 0x3C, master ACK, 0x96, master NACK
    tx0 = tx_cnt;
    bus.tx_data = 8'h3C;
    bus_start();
    xfer_byte(8'h85, ob);
    xfer_bit(1'b1, o);
    check_eq("rd_addr_ack", o, 1'b0);
    xfer_byte(8'hFF, ob);
    check_eq("rd_byte0", ob, 8'h3C);
    bus.tx_data = 8'h96;
    xfer_bit(1'b0, o);
    xfer_byte(8'hFF, ob);
    check_eq("rd_byte1", ob, 8'h96);
    xfer_bit(1'b1, o);
    check_eq("rd_nack_seen", o, 1'b1);
    wait_clk(Q + 2);
    check_eq("rd_sda_released", sda, 1'b1);
    check_eq("rd_busy_after_nack", bus.busy, 1'b0);
    check_eq("rd_tx_next_count", tx_cnt - tx0, 2);
    bus_stop();

    // Address 0x43+W is ignored
    rx0 = rx_cnt;
    bus_start();
    xfer_byte(8'h86, ob);
    xfer_bit(1'b1, o);
    check_eq("miss_no_ack", o, 1'b1);
    check_eq("miss_busy", bus.busy, 1'b0);
    xfer_byte(8'hFF, ob);
    check_eq("miss_no_drive", ob, 8'hFF);
    xfer_bit(1'b1, o);
    check_eq("miss_no_ack2", o, 1'b1);
    check_eq("miss_rx_count", rx_cnt - rx0, 0);
    bus_stop();

    // Write, repeated START after 4 data bits, then read
    rx0 = rx_cnt;
    bus.tx_data = 8'hC3;
    bus_start();
    xfer_byte(8'h84, ob);
    xfer_bit(1'b1, o);
    xfer_bit(1'b1, o);
    xfer_bit(1'b0, o);
    xfer_bit(1'b1, o);
    xfer_bit(1'b0, o);
    bus_rep_start();
    xfer_byte(8'h85, ob);
    xfer_bit(1'b1, o);
    check_eq("rs_addr_ack", o, 1'b0);
    xfer_byte(8'hFF, ob);
    check_eq("rs_rd_byte", ob, 8'hC3);
    xfer_bit(1'b1, o);
    check_eq("rs_rx_count", rx_cnt - rx0, 0);
    bus_stop();

    // STOP between data bits 3 and 4
    bus_start();
    xfer_byte(8'h84, ob);
    xfer_bit(1'b1, o);
    xfer_bit(1'b1, o);
    xfer_bit(1'b1, o);
    xfer_bit(1'b0, o);
    wait_clk(Q);
    m_pull = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    m_pull = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("stop_state_idle", dut.state_q, ST_IDLE);
    check_eq("stop_sda", sda, 1'b1);
    check_eq("stop_busy", bus.busy, 1'b0);
    wait_clk(2 * Q);

    // Reset while the address ACK is driven low
    bus_start();
    xfer_byte(8'h84, ob);
    wait_clk(Q);
    m_pull = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    check_eq("rst_ack_low", sda, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_sda", sda, 1'b1);
    check_eq("rst_mid_rx_data", bus.rx_data, 8'h00);
    check_eq("rst_mid_rx_valid", bus.rx_valid, 1'b0);
    check_eq("rst_mid_tx_next", bus.tx_next, 1'b0);
    check_eq("rst_mid_busy", bus.busy, 1'b0);
    wait_clk(Q);
    bus.scl = 1'b0;
    wait_clk(Q);
    rst = 1'b0;
    wait_clk(2);
    bus_stop();

    rx0 = rx_cnt;
    bus_start();
    xfer_byte(8'h84, ob);
    xfer_bit(1'b1, o);
    check_eq("post_rst_addr_ack", o, 1'b0);
    xfer_byte(8'h5A, ob);
    xfer_bit(1'b1, o);
    check_eq("post_rst_data_ack", o, 1'b0);
    check_eq("post_rst_rx_count", rx_cnt - rx0, 1);
    check_eq("post_rst_rx_data", last_rx, 8'h5A);
    bus_stop();
    check_eq("post_rst_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
